// File: rtl/chan_err_inj_if.sv
// Signal bundle for the channel error injector: configuration, symbol stream in/out and run status.
// Stream semantics: valid-only, no back-pressure. A symbol is taken on every rising clk edge where
// valid_i is high, and valid_o/sym_o/err_o carry that symbol exactly one cycle later.
interface chan_err_inj_if #(
  parameter int W  = 2,
  parameter int CW = 16,
  parameter int EW = 16
);
  logic          start;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_burst_len;
  logic [7:0]    cfg_thresh;
  logic [W-1:0]  cfg_mask;
  logic [CW-1:0] cfg_window;
  logic          valid_i;
  logic [W-1:0]  sym_i;
  logic          valid_o;
  logic [W-1:0]  sym_o;
  logic [W-1:0]  err_o;
  logic          active_o;
  logic          done_o;
  logic [CW-1:0] sym_ct_o;
  logic [EW-1:0] bit_err_ct_o;
  logic [1:0]    dbg_state;

  modport master (
    output start, cfg_mode, cfg_period, cfg_burst_len, cfg_thresh, cfg_mask, cfg_window,
    output valid_i, sym_i,
    input  valid_o, sym_o, err_o, active_o, done_o, sym_ct_o, bit_err_ct_o, dbg_state
  );

  modport slave (
    input  start, cfg_mode, cfg_period, cfg_burst_len, cfg_thresh, cfg_mask, cfg_window,
    input  valid_i, sym_i,
    output valid_o, sym_o, err_o, active_o, done_o, sym_ct_o, bit_err_ct_o, dbg_state
  );
endinterface

// File: rtl/chan_err_inj.sv
// Runtime-configurable channel corruption model: XORs a lane mask onto selected symbols
// (off / periodic burst / LFSR random / single shot) inside a bounded window, with saturating stats.
module chan_err_inj #(
  parameter int          W    = 2,
  parameter int          CW   = 16,
  parameter int          EW   = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic            clk,
  input logic            rst,
  chan_err_inj_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] M_PERIODIC = 2'd1;
  localparam logic [1:0] M_RANDOM   = 2'd2;
  localparam logic [1:0] M_SINGLE   = 2'd3;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [1:0]    r_mode;
  logic [CW-1:0] r_period;
  logic [CW-1:0] r_burst;
  logic [7:0]    r_thresh;
  logic [W-1:0]  r_mask;
  logic [CW-1:0] r_window;
  logic [CW-1:0] r_sym_ct;
  logic [EW-1:0] r_bit_ct;
  logic [CW-1:0] r_phase;
  logic [15:0]   r_lfsr;
  logic          r_single_done;
  logic          r_valid_o;
  logic [W-1:0]  r_sym_o;
  logic [W-1:0]  r_err_o;

  logic [1:0]    w_mode;
  logic [CW-1:0] w_period;
  logic [CW-1:0] w_burst;
  logic [7:0]    w_thresh;
  logic [W-1:0]  w_mask;
  logic [CW-1:0] w_window;
  logic [CW-1:0] w_sym_ct;
  logic [EW-1:0] w_bit_ct;
  logic [CW-1:0] w_phase;
  logic [15:0]   w_lfsr;
  logic          w_single_done;

  logic          w_run;
  logic          w_take;
  logic          w_hit;
  logic          w_last;
  logic [W-1:0]  w_flip;
  logic [EW:0]   w_pop;
  logic [EW:0]   w_bit_sum;
  logic [EW-1:0] w_bit_nxt;
  logic [CW-1:0] w_sym_nxt;
  logic [CW-1:0] w_phase_nxt;
  logic [15:0]   w_lfsr_step;

  // A start pulse takes effect in its own cycle: a symbol arriving with it sees the new
  // configuration and cleared run state, so it becomes index 0 of the new run.
  always_comb begin
    w_mode        = r_mode;
    w_period      = r_period;
    w_burst       = r_burst;
    w_thresh      = r_thresh;
    w_mask        = r_mask;
    w_window      = r_window;
    w_sym_ct      = r_sym_ct;
    w_bit_ct      = r_bit_ct;
    w_phase       = r_phase;
    w_lfsr        = r_lfsr;
    w_single_done = r_single_done;
    if (bus.start) begin
      w_mode        = bus.cfg_mode;
      w_period      = bus.cfg_period;
      w_burst       = bus.cfg_burst_len;
      w_thresh      = bus.cfg_thresh;
      w_mask        = bus.cfg_mask;
      w_window      = bus.cfg_window;
      w_sym_ct      = '0;
      w_bit_ct      = '0;
      w_phase       = '0;
      w_lfsr        = SEED;
      w_single_done = 1'b0;
    end
  end

  assign w_run  = bus.start || (r_state == S_RUN);
  assign w_take = w_run && bus.valid_i;

  always_comb begin
    w_hit = 1'b0;
    case (w_mode)
      M_PERIODIC: w_hit = (w_period != '0) && (w_burst != '0) &&
                          ((w_burst >= w_period) || (w_phase >= (w_period - w_burst)));
      M_RANDOM:   w_hit = (w_lfsr[7:0] < w_thresh);
      M_SINGLE:   w_hit = !w_single_done && (w_sym_ct == w_period);
      default:    w_hit = 1'b0;
    endcase
  end

  assign w_flip = (w_take && w_hit) ? w_mask : '0;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) begin
      w_pop = w_pop + {{EW{1'b0}}, w_flip[i]};
    end
  end

  assign w_bit_sum   = {1'b0, w_bit_ct} + w_pop;
  assign w_bit_nxt   = w_bit_sum[EW] ? '1 : w_bit_sum[EW-1:0];
  assign w_sym_nxt   = (&w_sym_ct) ? w_sym_ct : (w_sym_ct + CW'(1));
  assign w_phase_nxt = (w_period == '0) ? '0 :
                       (w_phase >= (w_period - CW'(1))) ? '0 : (w_phase + CW'(1));
  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign w_lfsr_step = {1'b0, w_lfsr[15:1]} ^ (w_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_last      = w_take && (w_window != '0) && (w_sym_ct == (w_window - CW'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = w_last ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (bus.start) w_state_nxt = w_last ? S_DONE : S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode        <= '0;
      r_period      <= '0;
      r_burst       <= '0;
      r_thresh      <= '0;
      r_mask        <= '0;
      r_window      <= '0;
      r_sym_ct      <= '0;
      r_bit_ct      <= '0;
      r_phase       <= '0;
      r_lfsr        <= SEED;
      r_single_done <= 1'b0;
      r_valid_o     <= 1'b0;
      r_sym_o       <= '0;
      r_err_o       <= '0;
    end else begin
      r_valid_o <= bus.valid_i;
      r_sym_o   <= bus.sym_i ^ w_flip;
      r_err_o   <= w_flip;
      if (bus.start) begin
        r_mode   <= bus.cfg_mode;
        r_period <= bus.cfg_period;
        r_burst  <= bus.cfg_burst_len;
        r_thresh <= bus.cfg_thresh;
        r_mask   <= bus.cfg_mask;
        r_window <= bus.cfg_window;
      end
      // Outside RUN (and without start) every statistic and generator holds.
      if (w_run) begin
        r_sym_ct      <= w_take ? w_sym_nxt : w_sym_ct;
        r_bit_ct      <= w_take ? w_bit_nxt : w_bit_ct;
        r_phase       <= w_take ? w_phase_nxt : w_phase;
        r_lfsr        <= w_take ? w_lfsr_step : w_lfsr;
        r_single_done <= w_single_done || (w_take && w_hit && (w_mode == M_SINGLE));
      end
    end
  end

  assign bus.valid_o      = r_valid_o;
  assign bus.sym_o        = r_sym_o;
  assign bus.err_o        = r_err_o;
  assign bus.active_o     = (r_state == S_RUN);
  assign bus.done_o       = (r_state == S_DONE);
  assign bus.sym_ct_o     = r_sym_ct;
  assign bus.bit_err_ct_o = r_bit_ct;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_chan_err_inj.sv
// Directed bench for chan_err_inj: passthrough, periodic, random, single-shot, restart,
// saturation (CW=4 instance) and asynchronous reset with LFSR reseed.
module tb_chan_err_inj;
  localparam int W  = 2;
  localparam int CW = 16;
  localparam int EW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [W-1:0] exp_q[$];

  chan_err_inj_if #(.W(W), .CW(CW), .EW(EW)) bus();
  chan_err_inj_if #(.W(W), .CW(4),  .EW(EW)) sbus();

  chan_err_inj #(.W(W), .CW(CW), .EW(EW), .SEED(16'hACE1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  chan_err_inj #(.W(W), .CW(4), .EW(EW), .SEED(16'hACE1)) u_sat (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.start = 1'b0; bus.cfg_mode = '0; bus.cfg_period = '0; bus.cfg_burst_len = '0;
    bus.cfg_thresh = '0; bus.cfg_mask = '0; bus.cfg_window = '0; bus.valid_i = 1'b0; bus.sym_i = '0;
    sbus.start = 1'b0; sbus.cfg_mode = '0; sbus.cfg_period = '0; sbus.cfg_burst_len = '0;
    sbus.cfg_thresh = '0; sbus.cfg_mask = '0; sbus.cfg_window = '0; sbus.valid_i = 1'b0; sbus.sym_i = '0;
  endtask

  task automatic drive_start(input logic [1:0] mode, input logic [CW-1:0] period,
                             input logic [CW-1:0] burst, input logic [7:0] thresh,
                             input logic [W-1:0] mask, input logic [CW-1:0] window);
    bus.cfg_mode = mode; bus.cfg_period = period; bus.cfg_burst_len = burst;
    bus.cfg_thresh = thresh; bus.cfg_mask = mask; bus.cfg_window = window;
    bus.valid_i = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drive_sym(input logic v, input logic [W-1:0] s);
    bus.valid_i = v; bus.sym_i = s;
    tick();
  endtask

  // Reference x^16+x^14+x^13+x^11+1 Galois step.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    logic lsb;
    lsb = v[0];
    v = v >> 1;
    if (lsb) v = v ^ 16'hB400;
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    n_vec++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
    n_vec++; if (bus.sym_o !== 2'b00) begin n_bad++; $display("FAIL reset_sym got %b want 00", bus.sym_o); end
    n_vec++; if (bus.err_o !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b want 00", bus.err_o); end
    n_vec++; if (bus.active_o !== 1'b0 || bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_status got %b%b want 00", bus.active_o, bus.done_o); end
    n_vec++; if (bus.sym_ct_o !== 16'd0 || bus.bit_err_ct_o !== 16'd0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.sym_ct_o, bus.bit_err_ct_o); end
    @(negedge clk);
    rst = 1'b1;
    bus.valid_i = 1'b1; bus.sym_i = 2'b11;
    tick();
    n_vec++; if (bus.dbg_state !== 2'd0 || bus.sym_o !== 2'b11 || bus.sym_ct_o !== 16'd0) begin
      n_bad++; $display("FAIL idle_passthru state=%0d sym=%b ct=%0d want 0/11/0", bus.dbg_state, bus.sym_o, bus.sym_ct_o);
    end
    bus.valid_i = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    logic [W-1:0] s;
    drive_start(2'd0, 16'd0, 16'd0, 8'd0, 2'b11, 16'd0);
    n_vec++; if (bus.active_o !== 1'b1 || bus.dbg_state !== 2'd1) begin n_bad++; $display("FAIL pass_active got %b/%0d want 1/1", bus.active_o, bus.dbg_state); end
    for (int i = 0; i < 20; i++) begin
      s = (i % 2 == 0) ? 2'b10 : 2'b01;
      drive_sym(1'b1, s);
      n_vec++; if (bus.valid_o !== 1'b1 || bus.sym_o !== s || bus.err_o !== 2'b00) begin
        n_bad++; $display("FAIL pass_sym i=%0d got v=%b s=%b e=%b want 1/%b/00", i, bus.valid_o, bus.sym_o, bus.err_o, s);
      end
    end
    drive_sym(1'b0, 2'b00);
    n_vec++; if (bus.sym_ct_o !== 16'd20 || bus.bit_err_ct_o !== 16'd0) begin
      n_bad++; $display("FAIL pass_counts got %0d/%0d want 20/0", bus.sym_ct_o, bus.bit_err_ct_o);
    end
  endtask

  task automatic test_periodic();
    logic [W-1:0] s, e;
    drive_start(2'd1, 16'd32, 16'd4, 8'd0, 2'b01, 16'd256);
    for (int k = 0; k < 256; k++) begin
      s = W'(k);
      e = ((k % 32) >= 28) ? 2'b01 : 2'b00;
      drive_sym(1'b1, s);
      n_vec++; if (bus.sym_o !== (s ^ e) || bus.err_o !== e) begin
        n_bad++; $display("FAIL per_sym k=%0d got s=%b e=%b want %b/%b", k, bus.sym_o, bus.err_o, s ^ e, e);
      end
      if (k == 254) begin
        n_vec++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL per_early_done k=254 got %b want 0", bus.done_o); end
      end
    end
    n_vec++; if (bus.done_o !== 1'b1 || bus.active_o !== 1'b0) begin n_bad++; $display("FAIL per_done got %b/%b want 1/0", bus.done_o, bus.active_o); end
    n_vec++; if (bus.sym_ct_o !== 16'd256 || bus.bit_err_ct_o !== 16'd32) begin
      n_bad++; $display("FAIL per_counts got %0d/%0d want 256/32", bus.sym_ct_o, bus.bit_err_ct_o);
    end
    for (int k = 0; k < 8; k++) begin
      drive_sym(1'b1, 2'b11);
      n_vec++; if (bus.sym_o !== 2'b11 || bus.err_o !== 2'b00) begin
        n_bad++; $display("FAIL per_after k=%0d got %b/%b want 11/00", k, bus.sym_o, bus.err_o);
      end
    end
    drive_sym(1'b0, 2'b00);
    n_vec++; if (bus.sym_ct_o !== 16'd256 || bus.done_o !== 1'b1) begin
      n_bad++; $display("FAIL per_hold got %0d/%b want 256/1", bus.sym_ct_o, bus.done_o);
    end
  endtask

  task automatic test_random();
    logic [15:0]  lfsr;
    logic [W-1:0] e;
    logic [W-1:0] hand [4];
    int flips;
    hand[0] = 2'b00; hand[1] = 2'b11; hand[2] = 2'b11; hand[3] = 2'b00;
    drive_start(2'd2, 16'd0, 16'd0, 8'd0, 2'b11, 16'd100);
    for (int k = 0; k < 100; k++) begin
      drive_sym(1'b1, W'(k));
      n_vec++; if (bus.err_o !== 2'b00) begin n_bad++; $display("FAIL rnd0_err k=%0d got %b want 00", k, bus.err_o); end
    end
    drive_sym(1'b0, 2'b00);
    n_vec++; if (bus.bit_err_ct_o !== 16'd0 || bus.done_o !== 1'b1) begin
      n_bad++; $display("FAIL rnd0_counts got %0d/%b want 0/1", bus.bit_err_ct_o, bus.done_o);
    end
    drive_start(2'd2, 16'd0, 16'd0, 8'd128, 2'b11, 16'd1000);
    lfsr = 16'hACE1;
    flips = 0;
    for (int k = 0; k < 1000; k++) begin
      e = (lfsr[7:0] < 8'd128) ? 2'b11 : 2'b00;
      drive_sym(1'b1, W'(k));
      if (k < 4) begin
        n_vec++; if (bus.err_o !== hand[k]) begin n_bad++; $display("FAIL rnd_hand k=%0d got %b want %b", k, bus.err_o, hand[k]); end
      end
      n_vec++; if (bus.err_o !== e || bus.sym_o !== (W'(k) ^ e)) begin
        n_bad++; $display("FAIL rnd_sym k=%0d got e=%b s=%b want %b/%b", k, bus.err_o, bus.sym_o, e, W'(k) ^ e);
      end
      if (e != 2'b00) flips++;
      lfsr = ref_lfsr(lfsr);
    end
    drive_sym(1'b0, 2'b00);
    n_vec++; if (bus.bit_err_ct_o !== EW'(2 * flips) || bus.sym_ct_o !== 16'd1000 || bus.done_o !== 1'b1) begin
      n_bad++; $display("FAIL rnd_counts got %0d/%0d/%b want %0d/1000/1", bus.bit_err_ct_o, bus.sym_ct_o, bus.done_o, 2 * flips);
    end
  endtask

  task automatic test_single_gaps();
    logic [W-1:0] e;
    int n;
    drive_start(2'd3, 16'd5, 16'd0, 8'd0, 2'b10, 16'd0);
    n = 0;
    for (int c = 0; c < 24; c++) begin
      if (c % 2 == 0) begin
        e = (n == 5) ? 2'b10 : 2'b00;
        drive_sym(1'b1, 2'b01);
        n++;
        n_vec++; if (bus.err_o !== e || bus.sym_o !== (2'b01 ^ e) || bus.sym_ct_o !== CW'(n)) begin
          n_bad++; $display("FAIL sgl_sym n=%0d got e=%b s=%b ct=%0d want %b/%b/%0d", n - 1, bus.err_o, bus.sym_o, bus.sym_ct_o, e, 2'b01 ^ e, n);
        end
      end else begin
        drive_sym(1'b0, 2'b01);
        n_vec++; if (bus.valid_o !== 1'b0 || bus.err_o !== 2'b00 || bus.sym_ct_o !== CW'(n)) begin
          n_bad++; $display("FAIL sgl_gap c=%0d got v=%b e=%b ct=%0d want 0/00/%0d", c, bus.valid_o, bus.err_o, bus.sym_ct_o, n);
        end
      end
    end
    n_vec++; if (bus.bit_err_ct_o !== 16'd1) begin n_bad++; $display("FAIL sgl_bits got %0d want 1", bus.bit_err_ct_o); end
  endtask

  task automatic test_restart();
    logic [W-1:0] e;
    drive_start(2'd1, 16'd4, 16'd1, 8'd0, 2'b01, 16'd0);
    for (int k = 0; k < 6; k++) begin
      e = (k % 4 == 3) ? 2'b01 : 2'b00;
      drive_sym(1'b1, 2'b00);
      n_vec++; if (bus.err_o !== e) begin n_bad++; $display("FAIL rst_pre k=%0d got %b want %b", k, bus.err_o, e); end
    end
    bus.cfg_mode = 2'd3; bus.cfg_period = 16'd0; bus.cfg_burst_len = 16'd0;
    bus.cfg_mask = 2'b11; bus.cfg_window = 16'd0; bus.start = 1'b1;
    drive_sym(1'b1, 2'b00);
    bus.start = 1'b0;
    n_vec++; if (bus.err_o !== 2'b11 || bus.sym_o !== 2'b11) begin n_bad++; $display("FAIL restart_sym got %b/%b want 11/11", bus.err_o, bus.sym_o); end
    n_vec++; if (bus.sym_ct_o !== 16'd1 || bus.bit_err_ct_o !== 16'd2 || bus.active_o !== 1'b1) begin
      n_bad++; $display("FAIL restart_counts got %0d/%0d/%b want 1/2/1", bus.sym_ct_o, bus.bit_err_ct_o, bus.active_o);
    end
    drive_sym(1'b1, 2'b00);
    n_vec++; if (bus.err_o !== 2'b00 || bus.sym_ct_o !== 16'd2) begin
      n_bad++; $display("FAIL restart_next got %b/%0d want 00/2", bus.err_o, bus.sym_ct_o);
    end
    drive_sym(1'b0, 2'b00);
  endtask

  task automatic test_saturation();
    logic [W-1:0] e;
    int ct;
    sbus.cfg_mode = 2'd1; sbus.cfg_period = 4'd3; sbus.cfg_burst_len = 4'd1;
    sbus.cfg_thresh = 8'd0; sbus.cfg_mask = 2'b01; sbus.cfg_window = 4'd0;
    sbus.valid_i = 1'b0; sbus.start = 1'b1;
    tick();
    sbus.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      e = (k % 3 == 2) ? 2'b01 : 2'b00;
      ct = (k + 1 > 15) ? 15 : k + 1;
      sbus.valid_i = 1'b1; sbus.sym_i = 2'b10;
      tick();
      n_vec++; if (sbus.err_o !== e || sbus.sym_ct_o !== 4'(ct)) begin
        n_bad++; $display("FAIL sat_sym k=%0d got e=%b ct=%0d want %b/%0d", k, sbus.err_o, sbus.sym_ct_o, e, ct);
      end
    end
    sbus.valid_i = 1'b0;
    tick();
    n_vec++; if (sbus.sym_ct_o !== 4'd15 || sbus.bit_err_ct_o !== 16'd6 || sbus.active_o !== 1'b1) begin
      n_bad++; $display("FAIL sat_final got %0d/%0d/%b want 15/6/1", sbus.sym_ct_o, sbus.bit_err_ct_o, sbus.active_o);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0]  lfsr;
    logic [W-1:0] e;
    drive_start(2'd2, 16'd0, 16'd0, 8'd128, 2'b11, 16'd0);
    lfsr = 16'hACE1;
    for (int k = 0; k < 12; k++) begin
      e = (lfsr[7:0] < 8'd128) ? 2'b11 : 2'b00;
      exp_q.push_back(e);
      lfsr = ref_lfsr(lfsr);
      drive_sym(1'b1, 2'b00);
      n_vec++; if (bus.err_o !== e) begin n_bad++; $display("FAIL ar_run1 k=%0d got %b want %b", k, bus.err_o, e); end
    end
    bus.valid_i = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_vec++; if (bus.valid_o !== 1'b0 || bus.sym_o !== 2'b00 || bus.err_o !== 2'b00) begin
      n_bad++; $display("FAIL ar_data got %b/%b/%b want 0/00/00", bus.valid_o, bus.sym_o, bus.err_o);
    end
    n_vec++; if (bus.active_o !== 1'b0 || bus.done_o !== 1'b0 || bus.dbg_state !== 2'd0) begin
      n_bad++; $display("FAIL ar_state got %b/%b/%0d want 0/0/0", bus.active_o, bus.done_o, bus.dbg_state);
    end
    n_vec++; if (bus.sym_ct_o !== 16'd0 || bus.bit_err_ct_o !== 16'd0) begin
      n_bad++; $display("FAIL ar_counts got %0d/%0d want 0/0", bus.sym_ct_o, bus.bit_err_ct_o);
    end
    bus.valid_i = 1'b0;
    #2 rst = 1'b1;
    tick();
    n_vec++; if (bus.dbg_state !== 2'd0) begin n_bad++; $display("FAIL ar_idle got %0d want 0", bus.dbg_state); end
    drive_start(2'd2, 16'd0, 16'd0, 8'd128, 2'b11, 16'd0);
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front();
      drive_sym(1'b1, 2'b00);
      n_vec++; if (bus.err_o !== e) begin n_bad++; $display("FAIL ar_run2 k=%0d got %b want %b", k, bus.err_o, e); end
    end
    drive_sym(1'b0, 2'b00);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_passthrough();
    test_periodic();
    test_random();
    test_single_gaps();
    test_restart();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
